// File: rtl/ksa.sv
// ----------------------------------------------------------------------------
// ksa - ARC4 key-scheduling stage.
//
// Walks i = 0..255 over the S memory. The init stage has already written
// S[i] = i. For each i the stage computes j = j + S[i] + key[i mod KEY_BYTES]
// (8-bit wrap) and then swaps S[i] and S[j]. S is a single-port 256x8 memory
// with synchronous read. It is shared with the neighbouring stages through
// an external mux.
//
// Ports:
//   clk     in   clock, all logic on posedge
//   rst     in   synchronous active-high reset
//   en      in   start request, sampled only while rdy=1
//   rdy     out  1 = idle and able to accept en
//   key     in   secret key, byte 0 is the most significant byte
//   addr    out  S memory address
//   rddata  in   S memory read data, valid the cycle after addr
//   wrdata  out  S memory write data
//   wren    out  S memory write enable
//
// Build option:
//   KSA_KEY_LATCH_EN  when defined, key is captured on the en-accept cycle,
//                     so key changes during a run have no effect on it.
//                     When undefined, key is used live.
// ----------------------------------------------------------------------------
module ksa #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_SI = 3'd1,
        WT_SI = 3'd2,
        RD_SJ = 3'd3,
        WT_SJ = 3'd4,
        WR_SI = 3'd5,
        WR_SJ = 3'd6
    } state_t;

    state_t  state_q, state_d;
    logic [7:0]    i_q, i_d;
    logic [7:0]    j_q, j_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [7:0]    si_q, si_d;
    logic [7:0]    sj_q, sj_d;
    logic [8*KEY_BYTES-1:0] key_use;
    logic [7:0]    kbyte;

`ifdef KSA_KEY_LATCH_EN
    logic [8*KEY_BYTES-1:0] key_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q <= '0;
        end else if (state_q == IDLE && en) begin
            key_q <= key;
        end
    end

    assign key_use = key_q;
`else
    assign key_use = key;
`endif

    // Key byte selected by the wrapping counter kidx; avoids an i mod KEY_BYTES divider.
    always_comb begin
        kbyte = '0;
        for (int unsigned n = 0; n < KEY_BYTES; n++) begin
            if (kidx_q == KW'(n)) begin
                kbyte = key_use[8*KEY_BYTES-1-8*n -: 8];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = IDLE;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        si_d    = si_q;
        sj_d    = sj_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = RD_SI;
                end
            end
            RD_SI: state_d = WT_SI;
            WT_SI: begin
                si_d    = rddata;
                j_d     = j_q + rddata + kbyte;
                state_d = RD_SJ;
            end
            RD_SJ: state_d = WT_SJ;
            WT_SJ: begin
                sj_d    = rddata;
                state_d = WR_SI;
            end
            WR_SI: state_d = WR_SJ;
            WR_SJ: begin
                if (i_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + KW'(1);
                    state_d = RD_SI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs.
    always_comb begin
        rdy    = 1'b0;
        addr   = '0;
        wrdata = '0;
        wren   = 1'b0;
        case (state_q)
            IDLE:  rdy  = 1'b1;
            RD_SI: addr = i_q;
            RD_SJ: addr = j_q;
            WR_SI: begin
                addr   = i_q;
                wrdata = sj_q;
                wren   = 1'b1;
            end
            WR_SJ: begin
                addr   = j_q;
                wrdata = si_q;
                wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ksa.sv
// ----------------------------------------------------------------------------
// tb_ksa - directed testbench for ksa. It models the single-port S memory
// with synchronous read and checks the result against a software ARC4 KSA.
// ----------------------------------------------------------------------------
module tb_ksa;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    logic [7:0]  mem   [256];
    logic [7:0]  exp_s [256];
    logic [15:0] wlog  [$];

    int n_chk  = 0;
    int n_pass = 0;

    ksa #(.KEY_BYTES(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    always #5 clk = ~clk;

    // S memory: synchronous read returns the pre-write contents.
    always @(posedge clk) begin
        rddata <= mem[addr];
        if (wren) mem[addr] = wrdata;
    end

    always @(negedge clk) begin
        if (wren) wlog.push_back({addr, wrdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    endtask

    function automatic void model(input logic [23:0] k);
        int unsigned j;
        logic [7:0]  t;
        logic [7:0]  kb;
        j = 0;
        for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
        for (int i = 0; i < 256; i++) begin
            kb = 8'(k >> (8 * (2 - (i % 3))));
            j  = (j + 32'(exp_s[i]) + 32'(kb)) & 32'hFF;
            t  = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
        end
    endfunction

    function automatic int mism();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_s[i]) n++;
        return n;
    endfunction

    function automatic logic is_perm();
        bit seen [256];
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 256; i++) seen[mem[i]] = 1'b1;
        for (int i = 0; i < 256; i++) if (!seen[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic start_run();
        wlog.delete();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Counts negedges with rdy=0, starting from the first one after accept.
    task automatic run_wait(input bit pulses, input int keychg, output int cyc);
        cyc = 1;
        if (pulses) en = 1'b1;
        while (cyc < 4000) begin
            @(negedge clk);
            if (rdy) break;
            cyc++;
            en = pulses && (cyc == 500 || cyc == 1535);
            if (keychg != 0 && cyc == keychg) key = 24'hFFFFFF;
        end
        en = 1'b0;
        if (cyc >= 4000) check("run timeout", 32'(rdy), 32'd1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        en  = 1'b0;
        key = '0;
        preload();
        repeat (2) @(negedge clk);
        check("reset rdy",    32'(rdy),    32'd1);
        check("reset wren",   32'(wren),   32'd0);
        check("reset addr",   32'(addr),   32'd0);
        check("reset wrdata", 32'(wrdata), 32'd0);
        rst = 1'b0;

        // All-zero key: latency and first swaps.
        preload();
        key = 24'h000000;
        model(key);
        start_run();
        run_wait(1'b0, 0, cyc);
        check("k0 busy cycles", 32'(cyc), 32'd1536);
        check("k0 S mismatches", 32'(mism()), 32'd0);
        check("k0 write count", 32'(wlog.size()), 32'd512);
        if (wlog.size() >= 6) begin
            check("k0 wr0", 32'(wlog[0]), 32'h0000);
            check("k0 wr1", 32'(wlog[1]), 32'h0000);
            check("k0 wr2", 32'(wlog[2]), 32'h0101);
            check("k0 wr3", 32'(wlog[3]), 32'h0101);
            check("k0 wr4", 32'(wlog[4]), 32'h0203);
            check("k0 wr5", 32'(wlog[5]), 32'h0302);
        end else begin
            check("k0 early writes", 32'(wlog.size()), 32'd6);
        end

        // Key 05 00 00.
        preload();
        key = 24'h050000;
        model(key);
        start_run();
        run_wait(1'b0, 0, cyc);
        if (wlog.size() >= 2) begin
            check("k5 first WR_SI", 32'(wlog[0]), 32'h0005);
            check("k5 first WR_SJ", 32'(wlog[1]), 32'h0500);
        end else begin
            check("k5 early writes", 32'(wlog.size()), 32'd2);
        end
        check("k5 S mismatches", 32'(mism()), 32'd0);

        // Mid-run reset, then a full clean run.
        preload();
        key = 24'h000000;
        start_run();
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst rdy",  32'(rdy),  32'd1);
        check("midrst wren", 32'(wren), 32'd0);
        check("midrst addr", 32'(addr), 32'd0);
        rst = 1'b0;
        preload();
        model(key);
        start_run();
        run_wait(1'b0, 0, cyc);
        check("after rst busy cycles", 32'(cyc), 32'd1536);
        check("after rst S mismatches", 32'(mism()), 32'd0);

        // en pulses during a run are ignored.
        preload();
        key = 24'hC0FFEE;
        model(key);
        start_run();
        run_wait(1'b1, 0, cyc);
        check("pulse busy cycles", 32'(cyc), 32'd1536);
        check("pulse S mismatches", 32'(mism()), 32'd0);

        // Key changed at cycle 10 of a run.
        preload();
        key = 24'h0A0B0C;
        model(key);
        start_run();
        run_wait(1'b0, 10, cyc);
`ifdef KSA_KEY_LATCH_EN
        check("keychg latched S mismatches", 32'(mism()), 32'd0);
`else
        check("keychg live S differs", 32'(mism() != 0), 32'd1);
`endif

        // Random keys.
        for (int r = 0; r < 40; r++) begin
            preload();
            key = 24'($urandom);
            model(key);
            start_run();
            run_wait(1'b0, 0, cyc);
            check($sformatf("rnd%0d busy cycles", r), 32'(cyc), 32'd1536);
            check($sformatf("rnd%0d S mismatches key %06h", r, key), 32'(mism()), 32'd0);
            check($sformatf("rnd%0d permutation", r), 32'(is_perm()), 32'd1);
            check($sformatf("rnd%0d write count", r), 32'(wlog.size()), 32'd512);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
